// File: rtl/calc_pkg.sv
// Shared calculator-datapath definitions: converter FSM states, BCD digit
// constants and the minimum binary width needed for a given digit count.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int unsigned BCD_MAX = 9;
  localparam int unsigned DIGIT_W = 4;

  // Smallest width w with 2^w > 10^digits - 1.
  function automatic int unsigned min_bin_w(input int unsigned digits);
    longint unsigned max_val;
    int unsigned     w;
    max_val = 64'd1;
    for (int unsigned i = 0; i < digits; i++) max_val = max_val * 64'd10;
    max_val = max_val - 64'd1;
    w = 0;
    for (int unsigned i = 0; i < 63; i++) begin
      if ((64'd1 << i) <= max_val) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of reverse double-dabble: digits that reach
// 8 or more after the right shift are reduced by 3.
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= DIGIT_W'(8)) adjusted = digit - DIGIT_W'(3);
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter: one reverse double-dabble shift per
// clock with start/busy/done handshake and invalid-digit rejection.
module bcd_to_bin_seq
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [BIN_W-1:0]          bin_out
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(BIN_W - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(BCD_MAX);

  if (BIN_W < min_bin_w(DIGITS)) begin : g_width_check
    $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
  end

  state_t             state, state_next;
  logic [BCD_W-1:0]   sreg_bcd;
  logic [BIN_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BIN_W-1:0]   acc_shift;
  logic               invalid;

  always_comb begin
    invalid = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX) invalid = 1'b1;
    end
  end

  // Shift first, then correct digits on the post-shift BCD value.
  always_comb begin
    shifted   = {sreg_bcd, acc} >> 1;
    bcd_shift = shifted[BCD_W+BIN_W-1:BIN_W];
    acc_shift = shifted[BIN_W-1:0];
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (bcd_shift[g*DIGIT_W +: DIGIT_W]),
      .adjusted (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = invalid ? DONE : CONV;
      CONV: if (cnt == LAST_CNT) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONV);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_bcd <= '0;
      acc      <= '0;
      cnt      <= '0;
      bin_out  <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sreg_bcd <= bcd_in;
            acc      <= '0;
            cnt      <= '0;
            if (invalid) begin
              bin_out <= '0;
              err     <= 1'b1;
            end
          end
        end
        CONV: begin
          sreg_bcd <= bcd_adj;
          acc      <= acc_shift;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            bin_out <= acc_shift;
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed and random checks of bcd_to_bin_seq against a timeline model of
// the handshake and an arithmetic model of the BCD value.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy, done, err;
  logic [13:0] bin_out;

  int checks   = 0;
  int failures = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  always #5 clk = ~clk;

  // Decimal value of a packed BCD word, or -1 when any digit exceeds 9.
  function automatic int bcd_value(input logic [15:0] v);
    int r;
    logic [3:0] d;
    r = 0;
    for (int i = 3; i >= 0; i--) begin
      d = v[i*4 +: 4];
      if (d > 4'd9) return -1;
      r = r * 10 + int'(d);
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] b;
    int m;
    b = '0;
    m = n;
    for (int i = 0; i < 4; i++) begin
      b[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return b;
  endfunction

  // Timeline model: accept -> BIN_W busy cycles -> one done cycle -> idle.
  int          m_left;
  int          m_val;
  logic        exp_busy, exp_done, exp_err;
  logic [13:0] exp_bin, m_pending;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; exp_busy = 0; exp_done = 0; exp_err = 0;
      exp_bin = '0; m_pending = '0;
    end else if (exp_done) begin
      exp_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        exp_busy = 0; exp_done = 1; exp_err = 0; exp_bin = m_pending;
      end
    end else if (start) begin
      m_val = bcd_value(bcd_in);
      if (m_val < 0) begin
        exp_done = 1; exp_err = 1; exp_bin = '0;
      end else begin
        m_left = BIN_W; exp_busy = 1; m_pending = 14'(m_val);
      end
    end
  end

  always @(posedge clk) begin
    #3;
    checks++;
    if (busy !== exp_busy || done !== exp_done || err !== exp_err || bin_out !== exp_bin) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t busy=%b/%b done=%b/%b err=%b/%b bin_out=%0d/%0d (got/exp)",
               $time, busy, exp_busy, done, exp_done, err, exp_err, bin_out, exp_bin);
    end
    if (exp_done && !exp_err) begin
      checks++;
      if (dut.sreg_bcd !== '0) begin
        failures++;
        $display("FAIL sreg_bcd_zero t=%0t got=%h exp=0000", $time, dut.sreg_bcd);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic wait_done(input int limit, output int cyc, output int busy_cnt);
    bit seen;
    cyc = 0; busy_cnt = 0; seen = 0;
    while (!seen && cyc < limit) begin
      @(posedge clk); #3;
      cyc++;
      if (busy) busy_cnt++;
      if (done) seen = 1;
    end
  endtask

  // Issue one request; optionally pulse start again at cycles p1/p2 of the run.
  task automatic run(input logic [15:0] v, input int exp_bin, input bit exp_err,
                     input int p1, input int p2);
    int cyc, busy_cnt;
    bit seen;
    @(negedge clk);
    start = 1; bcd_in = v;
    cyc = 0; busy_cnt = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #3;
      cyc++;
      if (busy) busy_cnt++;
      if (done) seen = 1;
      start  = (cyc == p1 || cyc == p2);
      bcd_in = 16'($urandom);
    end
    start = 0;
    chk($sformatf("latency_%h", v), cyc, exp_err ? 1 : BIN_W + 1);
    chk($sformatf("busy_cycles_%h", v), busy_cnt, exp_err ? 0 : BIN_W);
    chk($sformatf("bin_out_%h", v), int'(bin_out), exp_bin);
    chk($sformatf("err_%h", v), int'(err), int'(exp_err));
    @(posedge clk); #3;
    chk($sformatf("done_single_%h", v), int'(done), 0);
  endtask

  initial begin
    int cyc, busy_cnt, n, dones;
    rst_n = 0; start = 0; bcd_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_bin", int'(bin_out), 0);

    run(16'h0000, 0, 0, -1, -1);
    run(16'h0015, 15, 0, -1, -1);
    run(16'h9999, 9999, 0, -1, -1);
    run(16'h12A4, 0, 1, -1, -1);
    run(16'h0042, 42, 0, -1, -1);

    // Mid-conversion start pulses are ignored, then start held from done.
    @(negedge clk);
    start = 1; bcd_in = 16'h1234;
    cyc = 0; busy_cnt = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #3;
      cyc++;
      if (busy) busy_cnt++;
      start = (cyc == 3 || cyc == 10);
    end
    chk("ign_latency", cyc, BIN_W + 1);
    chk("ign_busy_cycles", busy_cnt, BIN_W);
    chk("ign_bin_out", int'(bin_out), 1234);
    start = 1; bcd_in = 16'h0777;
    @(posedge clk); #3;
    chk("held_idle_busy", int'(busy), 0);
    chk("held_idle_done", int'(done), 0);
    @(posedge clk); #3;
    chk("held_accept_busy", int'(busy), 1);
    wait_done(40, cyc, busy_cnt);
    chk("held_latency", cyc, BIN_W);
    chk("held_bin_out", int'(bin_out), 777);
    @(posedge clk); #3;
    chk("held_idle2_busy", int'(busy), 0);
    @(posedge clk); #3;
    chk("held_accept2_busy", int'(busy), 1);
    start = 0;
    wait_done(40, cyc, busy_cnt);
    chk("held2_bin_out", int'(bin_out), 777);
    @(posedge clk); #3;

    // Reset mid-conversion aborts with no completion.
    @(negedge clk);
    start = 1; bcd_in = 16'h5678;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #3;
      start = 0;
    end
    chk("pre_abort_busy", int'(busy), 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_bin", int'(bin_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    dones = 0;
    repeat (20) begin
      @(posedge clk); #3;
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run(16'h5678, 5678, 0, -1, -1);

    for (int k = 0; k < 30; k++) begin
      n = int'($urandom_range(0, 9999));
      run(to_bcd(n), n, 0, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
